// File: rtl/urna_pkg.sv
// Shared types and constants for the voting-session controller.
package urna_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    OPEN,
    GRANT,
    COMMIT,
    RPT,
    CLOSED
  } state_t;

  localparam logic [1:0] COD_NULO = 2'd0;
  localparam logic [1:0] COD_C1   = 2'd1;
  localparam logic [1:0] COD_C2   = 2'd2;

  localparam logic [1:0] SEL_NULO = 2'd0;
  localparam logic [1:0] SEL_C1   = 2'd1;
  localparam logic [1:0] SEL_C2   = 2'd2;

  // Codes 0 and 3 both count as a null vote.
  function automatic logic [1:0] code_to_sel(input logic [1:0] code);
    case (code)
      COD_C1:  code_to_sel = SEL_C1;
      COD_C2:  code_to_sel = SEL_C2;
      default: code_to_sel = SEL_NULO;
    endcase
  endfunction

endpackage

// File: rtl/urna_sessao_ctrl_if.sv
// Terminal, poll-worker and tally signals of the session controller.
interface urna_sessao_ctrl_if #(
  parameter int NUM_TERM = 4,
  parameter int CNT_W    = 8
);
  logic                  open_s;
  logic                  close_s;
  logic [NUM_TERM-1:0]   req;
  logic [2*NUM_TERM-1:0] vote_code;
  logic [NUM_TERM-1:0]   unlock;
  logic                  tally_ready;
  logic [NUM_TERM-1:0]   ack;
  logic [NUM_TERM-1:0]   locked;
  logic                  tally_clr;
  logic                  tally_inc;
  logic [1:0]            tally_sel;
  logic                  rpt_strobe;
  logic [1:0]            rpt_sel;
  logic                  session_open;
  logic [CNT_W-1:0]      votes_cast;

  modport slave (
    input  open_s, close_s, req, vote_code, unlock, tally_ready,
    output ack, locked, tally_clr, tally_inc, tally_sel,
           rpt_strobe, rpt_sel, session_open, votes_cast
  );

  modport master (
    output open_s, close_s, req, vote_code, unlock, tally_ready,
    input  ack, locked, tally_clr, tally_inc, tally_sel,
           rpt_strobe, rpt_sel, session_open, votes_cast
  );
endinterface

// File: rtl/urna_rr_arb.sv
// Round-robin arbiter: first eligible terminal at or after the pointer wins.
module urna_rr_arb
  import urna_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int unsigned   cand;
  logic [IW-1:0] cidx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_i) + k) % N;
      cidx = IW'(cand);
      if (!any_o && elig_i[cidx]) begin
        any_o       = 1'b1;
        gnt_o[cidx] = 1'b1;
        idx_o       = cidx;
      end
    end
  end

endmodule

// File: rtl/urna_sessao_ctrl.sv
// Session controller: opens/closes the poll, arbitrates terminal votes into
// the shared tally and sequences the C1/C2/null result readout.
module urna_sessao_ctrl
  import urna_pkg::*;
#(
  parameter int NUM_TERM = 4,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  urna_sessao_ctrl_if.slave bus
);

  localparam int IW = (NUM_TERM > 2) ? $clog2(NUM_TERM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_TERM - 1);

  state_t              state_q;
  logic [IW-1:0]       ptr_q, idx_q;
  logic [NUM_TERM-1:0] gnt_q, lock_q, lock_d, ack_vec, elig;
  logic [1:0]          code_q, rpt_cnt_q, tally_sel_q, rpt_sel_q;
  logic                pend_q, tally_clr_q, tally_inc_q, rpt_strobe_q, session_open_q;
  logic [CNT_W-1:0]    votes_q;

  logic [NUM_TERM-1:0] arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [1:0]          arb_code;
  logic                commit_fire;

  assign elig = bus.req & ~lock_q;

  urna_rr_arb #(.N(NUM_TERM), .IW(IW)) u_arb (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  always_comb begin
    arb_code = COD_NULO;
    for (int unsigned i = 0; i < NUM_TERM; i++) begin
      if (arb_gnt[i]) arb_code = bus.vote_code[2*i +: 2];
    end
  end

  // Ack is combinational so it lands in the same cycle tally_ready is seen.
  assign commit_fire = (state_q == COMMIT) && bus.tally_ready;
  assign ack_vec     = commit_fire ? gnt_q : '0;

  // A fresh ack overrides a simultaneous unlock.
  always_comb begin
    lock_d = (lock_q & ~bus.unlock) | ack_vec;
    if (state_q == CLEAR) lock_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      idx_q          <= '0;
      gnt_q          <= '0;
      lock_q         <= '0;
      code_q         <= COD_NULO;
      rpt_cnt_q      <= '0;
      pend_q         <= 1'b0;
      tally_clr_q    <= 1'b0;
      tally_inc_q    <= 1'b0;
      tally_sel_q    <= SEL_NULO;
      rpt_strobe_q   <= 1'b0;
      rpt_sel_q      <= SEL_NULO;
      session_open_q <= 1'b0;
      votes_q        <= '0;
    end else begin
      lock_q      <= lock_d;
      tally_clr_q <= 1'b0;
      case (state_q)
        IDLE, CLOSED: begin
          if (bus.open_s) begin
            state_q     <= CLEAR;
            tally_clr_q <= 1'b1;
          end
        end
        CLEAR: begin
          votes_q        <= '0;
          pend_q         <= 1'b0;
          session_open_q <= 1'b1;
          state_q        <= OPEN;
        end
        OPEN: begin
          if (arb_any) begin
            idx_q   <= arb_idx;
            gnt_q   <= arb_gnt;
            code_q  <= arb_code;
            state_q <= GRANT;
          end else if (bus.close_s) begin
            session_open_q <= 1'b0;
            rpt_strobe_q   <= 1'b1;
            rpt_sel_q      <= SEL_C1;
            rpt_cnt_q      <= '0;
            state_q        <= RPT;
          end
        end
        GRANT: begin
          tally_sel_q <= code_to_sel(code_q);
          tally_inc_q <= 1'b1;
          state_q     <= COMMIT;
          if (bus.close_s) pend_q <= 1'b1;
        end
        COMMIT: begin
          if (bus.tally_ready) begin
            tally_inc_q <= 1'b0;
            if (votes_q != '1) votes_q <= votes_q + CNT_W'(1);
            ptr_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
            if (pend_q || bus.close_s) begin
              pend_q         <= 1'b0;
              session_open_q <= 1'b0;
              rpt_strobe_q   <= 1'b1;
              rpt_sel_q      <= SEL_C1;
              rpt_cnt_q      <= '0;
              state_q        <= RPT;
            end else begin
              state_q <= OPEN;
            end
          end else if (bus.close_s) begin
            pend_q <= 1'b1;
          end
        end
        RPT: begin
          case (rpt_cnt_q)
            2'd0: begin
              rpt_sel_q <= SEL_C2;
              rpt_cnt_q <= 2'd1;
            end
            2'd1: begin
              rpt_sel_q <= SEL_NULO;
              rpt_cnt_q <= 2'd2;
            end
            default: begin
              rpt_strobe_q <= 1'b0;
              rpt_sel_q    <= SEL_NULO;
              rpt_cnt_q    <= '0;
              state_q      <= CLOSED;
            end
          endcase
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack          = ack_vec;
  assign bus.locked       = lock_q;
  assign bus.tally_clr    = tally_clr_q;
  assign bus.tally_inc    = tally_inc_q;
  assign bus.tally_sel    = tally_sel_q;
  assign bus.rpt_strobe   = rpt_strobe_q;
  assign bus.rpt_sel      = rpt_sel_q;
  assign bus.session_open = session_open_q;
  assign bus.votes_cast   = votes_q;

endmodule

// File: tb/tb_urna_sessao_ctrl.sv
// Directed bench for urna_sessao_ctrl with hand-computed expectations.
module tb_urna_sessao_ctrl;

  localparam int NT = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  urna_sessao_ctrl_if #(.NUM_TERM(NT), .CNT_W(CW)) bus ();

  urna_sessao_ctrl #(.NUM_TERM(NT), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_inc(input string tag);
    for (int c = 0; c < 10 && !bus.tally_inc; c++) tick();
    check(tag, 32'(bus.tally_inc), 32'd1);
  endtask

  logic [3:0] exp_ack [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd0, 2'd0};
  logic [1:0] exp_rpt [3] = '{2'd1, 2'd2, 2'd0};

  int   n, inc_cnt, ack_cnt, inc_seen;
  logic got, rdy_set;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.open_s      = 1'b0;
    bus.close_s     = 1'b0;
    bus.req         = '0;
    bus.vote_code   = 8'b00_11_10_01;
    bus.unlock      = '0;
    bus.tally_ready = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_session_open", 32'(bus.session_open), 32'd0);
    check("rst_tally_inc",    32'(bus.tally_inc),    32'd0);
    check("rst_tally_clr",    32'(bus.tally_clr),    32'd0);
    check("rst_locked",       32'(bus.locked),       32'd0);
    check("rst_votes",        32'(bus.votes_cast),   32'd0);
    check("rst_rpt_strobe",   32'(bus.rpt_strobe),   32'd0);
    rst_n = 1'b1;
    tick();

    // open session
    bus.open_s = 1'b1; tick(); bus.open_s = 1'b0;
    check("clr_pulse",    32'(bus.tally_clr),    32'd1);
    check("clr_not_open", 32'(bus.session_open), 32'd0);
    tick();
    check("clr_done",     32'(bus.tally_clr),    32'd0);
    check("open_session", 32'(bus.session_open), 32'd1);
    check("open_votes",   32'(bus.votes_cast),   32'd0);
    check("open_locked",  32'(bus.locked),       32'd0);

    // all four terminals request at once
    bus.tally_ready = 1'b1;
    bus.req = 4'b1111;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick();
      if (bus.ack != '0) begin
        check("rr_ack", 32'(bus.ack),       32'(exp_ack[n]));
        check("rr_sel", 32'(bus.tally_sel), 32'(exp_sel[n]));
        check("rr_inc", 32'(bus.tally_inc), 32'd1);
        bus.req = bus.req & ~bus.ack;
        n++;
      end
    end
    check("rr_count", n, 32'd4);
    tick();
    check("rr_votes",  32'(bus.votes_cast), 32'd4);
    check("rr_locked", 32'(bus.locked),     32'hF);

    // T1 votes again with the tally stalled for 5 cycles
    bus.unlock = 4'b0010; tick(); bus.unlock = '0;
    check("unlock_t1", 32'(bus.locked), 32'hD);
    bus.tally_ready = 1'b0;
    bus.req = 4'b0010;
    inc_cnt = 0; ack_cnt = 0; rdy_set = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.tally_inc) begin
        inc_cnt++;
        check("stall_sel", 32'(bus.tally_sel), 32'd2);
      end else if (inc_cnt > 0) begin
        break;
      end
      if (inc_cnt == 6 && !rdy_set) begin
        bus.tally_ready = 1'b1;
        rdy_set = 1'b1;
      end
      #1;
      if (bus.ack != '0) begin
        ack_cnt++;
        check("stall_ack", 32'(bus.ack), 32'h2);
        bus.req = '0;
      end
    end
    check("stall_inc_cycles", inc_cnt, 32'd6);
    check("stall_ack_count",  ack_cnt, 32'd1);
    check("stall_votes", 32'(bus.votes_cast), 32'd5);

    // T0 re-votes; unlock coincides with its ack
    bus.unlock = 4'b0001; tick(); bus.unlock = '0;
    check("unlock_t0", 32'(bus.locked), 32'hE);
    bus.req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.ack != '0) begin
        got = 1'b1;
        check("revote_ack", 32'(bus.ack), 32'h1);
        bus.unlock = 4'b0001;
        bus.req = '0;
      end
    end
    check("revote_seen", 32'(got), 32'd1);
    tick();
    bus.unlock = '0;
    check("lock_wins",    32'(bus.locked),     32'hF);
    check("revote_votes", 32'(bus.votes_cast), 32'd6);

    // close arrives while T2 is in COMMIT
    bus.unlock = 4'b0100; tick(); bus.unlock = '0;
    bus.tally_ready = 1'b0;
    bus.req = 4'b0100;
    wait_inc("close_inc_seen");
    check("close_sel", 32'(bus.tally_sel), 32'd0);
    bus.close_s = 1'b1; tick(); bus.close_s = 1'b0;
    check("close_hold_inc",  32'(bus.tally_inc),    32'd1);
    check("close_hold_open", 32'(bus.session_open), 32'd1);
    check("close_no_rpt",    32'(bus.rpt_strobe),   32'd0);
    bus.tally_ready = 1'b1;
    #1;
    check("close_ack", 32'(bus.ack), 32'h4);
    bus.req = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rpt_strobe", 32'(bus.rpt_strobe), 32'd1);
      check("rpt_sel",    32'(bus.rpt_sel),    32'(exp_rpt[k]));
    end
    tick();
    check("rpt_end",        32'(bus.rpt_strobe),   32'd0);
    check("closed_session", 32'(bus.session_open), 32'd0);
    check("closed_votes",   32'(bus.votes_cast),   32'd7);

    // requests after close are ignored
    bus.unlock = 4'b1111; tick(); bus.unlock = '0;
    check("closed_unlock", 32'(bus.locked), 32'd0);
    bus.req = 4'b1111;
    ack_cnt = 0; inc_seen = 0;
    repeat (10) begin
      tick();
      if (bus.ack != '0) ack_cnt++;
      if (bus.tally_inc) inc_seen++;
    end
    check("closed_no_ack", ack_cnt,  32'd0);
    check("closed_no_inc", inc_seen, 32'd0);
    check("closed_votes_hold", 32'(bus.votes_cast), 32'd7);
    bus.req = '0;

    // reopen, commit one vote, then reset in the middle of the next COMMIT
    bus.open_s = 1'b1; tick(); bus.open_s = 1'b0; tick();
    check("reopen_votes",  32'(bus.votes_cast), 32'd0);
    check("reopen_locked", 32'(bus.locked),     32'd0);
    bus.tally_ready = 1'b1;
    bus.req = 4'b0001;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (bus.ack != '0) begin
        got = 1'b1;
        bus.req = '0;
      end
    end
    check("reopen_ack_seen", 32'(got), 32'd1);
    tick();
    check("reopen_votes1",  32'(bus.votes_cast), 32'd1);
    check("reopen_locked1", 32'(bus.locked),     32'h1);
    bus.tally_ready = 1'b0;
    bus.req = 4'b0010;
    wait_inc("rst_inc_seen");
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_inc",    32'(bus.tally_inc),    32'd0);
    check("rst_async_ack",    32'(bus.ack),          32'd0);
    check("rst_async_votes",  32'(bus.votes_cast),   32'd0);
    check("rst_async_locked", 32'(bus.locked),       32'd0);
    check("rst_async_open",   32'(bus.session_open), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    bus.tally_ready = 1'b1;
    inc_seen = 0;
    repeat (4) begin
      tick();
      if (bus.tally_inc) inc_seen++;
    end
    check("idle_no_grant", inc_seen, 32'd0);
    bus.req = '0;
    bus.close_s = 1'b1; tick(); bus.close_s = 1'b0; tick();
    check("idle_close_ignored", 32'(bus.rpt_strobe), 32'd0);

    // votes_cast saturates at all-ones
    bus.open_s = 1'b1; tick(); bus.open_s = 1'b0; tick();
    bus.unlock = 4'b0001;
    bus.req = 4'b0001;
    n = 0;
    for (int c = 0; c < 2000 && n < 260; c++) begin
      tick();
      if (bus.ack != '0) n++;
    end
    check("sat_acks", n, 32'd260);
    tick();
    check("sat_votes", 32'(bus.votes_cast), 32'd255);
    bus.req = '0;
    bus.unlock = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
